// File: rtl/ddf_kln_delay_line_if.sv
// Data and control bundle for ddf_kln_delay_line. The master side drives the
// word, enables and tap select, and the slave side returns the tapped word and status.
`timescale 1ns/1ps
interface ddf_kln_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SELW  = $clog2(DEPTH)
);
  logic [WIDTH-1:0] D;
  logic             EN;
  logic             CLR;
  logic             MODE;
  logic [SELW-1:0]  SEL;
  logic [WIDTH-1:0] Q;
  logic             QV;
  logic [SELW:0]    FILL;

  modport master (output D, EN, CLR, MODE, SEL, input Q, QV, FILL);
  modport slave  (input D, EN, CLR, MODE, SEL, output Q, QV, FILL);
endinterface

// File: rtl/ddf_kln_delay_line.sv
// Clearable multi-bit delay line with a selectable output tap, a saturating fill
// counter driving a valid flag, and a recirculate mode that loops the chain on its tap.
`timescale 1ns/1ps
module ddf_kln_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SELW  = $clog2(DEPTH)
) (
  input  logic                 CP,
  input  logic                 KLN,
  ddf_kln_delay_line_if.slave  bus
);

  localparam logic [SELW:0] FILL_MAX = (SELW+1)'(DEPTH);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [SELW:0]    r_fill;
  logic [SELW-1:0]  w_tap;
  logic [WIDTH-1:0] w_tap_word;

  // Out-of-range selects only exist when DEPTH is not a power of two.
  generate
    if ((1 << SELW) == DEPTH) begin : g_pow2
      assign w_tap = bus.SEL;
    end else begin : g_clamp
      assign w_tap = (bus.SEL > SELW'(DEPTH-1)) ? SELW'(DEPTH-1) : bus.SEL;
    end
  endgenerate

  assign w_tap_word = r_stage[w_tap];

  always_ff @(posedge CP or negedge KLN) begin
    if (!KLN) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      r_fill <= '0;
    end else if (bus.CLR) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      r_fill <= '0;
    end else if (bus.EN) begin
      r_stage[0] <= bus.MODE ? w_tap_word : bus.D;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      // Recirculation reuses old words, so it never adds to the valid count.
      if (!bus.MODE && (r_fill != FILL_MAX)) r_fill <= r_fill + 1'b1;
    end
  end

  assign bus.Q    = w_tap_word;
  assign bus.QV   = (r_fill > {1'b0, w_tap});
  assign bus.FILL = r_fill;

endmodule

// File: tb/tb_ddf_kln_delay_line.sv
// Bench for ddf_kln_delay_line: vector table with a scoreboard queue on an 8-deep
// line, plus hand sequences for live retap, async reset and a 6-deep clamped instance.
`timescale 1ns/1ps
module tb_ddf_kln_delay_line;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] q;
    logic       qv;
    logic [3:0] fill;
  } vec_t;

  logic CP  = 1'b0;
  logic KLN = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;
  vec_t tbl [$];
  vec_t sb  [$];

  ddf_kln_delay_line_if #(.WIDTH(8), .DEPTH(8)) ifa ();
  ddf_kln_delay_line_if #(.WIDTH(8), .DEPTH(6)) ifb ();

  ddf_kln_delay_line #(.WIDTH(8), .DEPTH(8)) u_a (.CP(CP), .KLN(KLN), .bus(ifa));
  ddf_kln_delay_line #(.WIDTH(8), .DEPTH(6)) u_b (.CP(CP), .KLN(KLN), .bus(ifb));

  always #5 CP = ~CP;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic en, input logic clr, input logic mode,
                              input logic [2:0] sel, input logic [7:0] d,
                              input logic [7:0] q, input logic qv, input logic [3:0] fill);
    vec_t v;
    v.en = en; v.clr = clr; v.mode = mode; v.sel = sel; v.d = d;
    v.q = q; v.qv = qv; v.fill = fill;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge CP);
    ifa.EN = v.en; ifa.CLR = v.clr; ifa.MODE = v.mode; ifa.SEL = v.sel; ifa.D = v.d;
    sb.push_back(v);
    @(posedge CP);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d_q", idx),    32'(ifa.Q),    32'(e.q));
    check($sformatf("vec%0d_qv", idx),   32'(ifa.QV),   32'(e.qv));
    check($sformatf("vec%0d_fill", idx), 32'(ifa.FILL), 32'(e.fill));
  endtask

  task automatic shift_a(input logic [7:0] d, input logic [2:0] sel);
    @(negedge CP);
    ifa.EN = 1'b1; ifa.CLR = 1'b0; ifa.MODE = 1'b0; ifa.SEL = sel; ifa.D = d;
    @(posedge CP);
    #1;
  endtask

  task automatic shift_b(input logic [7:0] d);
    @(negedge CP);
    ifb.EN = 1'b1; ifb.CLR = 1'b0; ifb.MODE = 1'b0; ifb.SEL = 3'd7; ifb.D = d;
    @(posedge CP);
    #1;
    ifb.EN = 1'b0;
  endtask

  initial begin
    ifa.D = '0; ifa.EN = 1'b0; ifa.CLR = 1'b0; ifa.MODE = 1'b0; ifa.SEL = '0;
    ifb.D = '0; ifb.EN = 1'b0; ifb.CLR = 1'b0; ifb.MODE = 1'b0; ifb.SEL = '0;

    // Reset and fill, clear priority, enable gaps, recirculate, mode return.
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'h11,8'h00,1'b0,4'd1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'h22,8'h00,1'b0,4'd2));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'h33,8'h00,1'b0,4'd3));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'h44,8'h11,1'b1,4'd4));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'h55,8'h22,1'b1,4'd5));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'h66,8'h33,1'b1,4'd6));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'h77,8'h44,1'b1,4'd7));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'h88,8'h55,1'b1,4'd8));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'h99,8'h66,1'b1,4'd8));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd3,8'hAA,8'h77,1'b1,4'd8));
    tbl.push_back(mk(1'b1,1'b1,1'b0,3'd3,8'hFF,8'h00,1'b0,4'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd7,8'hFF,8'h00,1'b0,4'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd0,8'h5A,8'h5A,1'b1,4'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,8'hA5,8'h5A,1'b1,4'd1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd0,8'hC3,8'hC3,1'b1,4'd2));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'd2,8'h00,8'h00,1'b0,4'd0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd2,8'h0A,8'h00,1'b0,4'd1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd2,8'h0B,8'h00,1'b0,4'd2));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd2,8'h0C,8'h0A,1'b1,4'd3));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(1'b1,1'b0,1'b1,3'd2,8'hFF,8'h0B,1'b1,4'd3));
      tbl.push_back(mk(1'b1,1'b0,1'b1,3'd2,8'hFF,8'h0C,1'b1,4'd3));
      tbl.push_back(mk(1'b1,1'b0,1'b1,3'd2,8'hFF,8'h0A,1'b1,4'd3));
    end
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd2,8'h77,8'h0B,1'b1,4'd4));
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'd0,8'h66,8'h66,1'b1,4'd5));

    // Reset state while KLN is low.
    #1;
    check("rst_a_q",    32'(ifa.Q),    32'h0);
    check("rst_a_qv",   32'(ifa.QV),   32'h0);
    check("rst_a_fill", 32'(ifa.FILL), 32'h0);
    check("rst_b_fill", 32'(ifb.FILL), 32'h0);
    @(negedge CP);
    KLN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Live retap: load 01..08, freeze, sweep SEL between edges.
    @(negedge CP);
    ifa.EN = 1'b0; ifa.CLR = 1'b1;
    @(posedge CP);
    #1;
    for (int i = 1; i <= 8; i++) shift_a(8'(i), 3'd7);
    @(negedge CP);
    ifa.EN = 1'b0;
    for (int s = 0; s < 8; s++) begin
      ifa.SEL = 3'(s);
      #1;
      check($sformatf("retap%0d_q", s),  32'(ifa.Q),  32'(8 - s));
      check($sformatf("retap%0d_qv", s), 32'(ifa.QV), 32'h1);
    end

    // Six-deep instance: SEL past the end clamps to the last stage.
    for (int i = 1; i <= 6; i++) shift_b(8'(i));
    check("d6_sel7_q",    32'(ifb.Q),    32'h01);
    check("d6_sel7_qv",   32'(ifb.QV),   32'h1);
    check("d6_fill",      32'(ifb.FILL), 32'h6);
    shift_b(8'h07);
    check("d6_shift_q",   32'(ifb.Q),    32'h02);
    check("d6_fill_sat",  32'(ifb.FILL), 32'h6);
    ifb.SEL = 3'd6;
    #1;
    check("d6_sel6_q",    32'(ifb.Q),    32'h02);

    // Async reset between edges, then latency restarts.
    shift_a(8'h21, 3'd1);
    shift_a(8'h22, 3'd1);
    shift_a(8'h23, 3'd1);
    check("pre_rst_q", 32'(ifa.Q), 32'h22);
    @(negedge CP);
    #2;
    ifa.EN = 1'b0;
    KLN = 1'b0;
    #1;
    check("arst_q",    32'(ifa.Q),    32'h0);
    check("arst_qv",   32'(ifa.QV),   32'h0);
    check("arst_fill", 32'(ifa.FILL), 32'h0);
    check("arst_b_q",  32'(ifb.Q),    32'h0);
    @(negedge CP);
    KLN = 1'b1;
    apply(mk(1'b1,1'b0,1'b0,3'd1,8'h3C,8'h00,1'b0,4'd1), 100);
    apply(mk(1'b1,1'b0,1'b0,3'd1,8'h3D,8'h3C,1'b1,4'd2), 101);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
